// File: rtl/cpu_run_sequencer.sv
// Run controller for the 9-bit accumulator CPU: Start/Done handshake, FETCH/EXEC/MEMWAIT
// sequencing, a single commit strobe gating datapath writes, run counters and a watchdog.
module cpu_run_sequencer #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Halt_Dec,
    input  logic             Load_Dec,
    output logic             PC_Rst,
    output logic             IR_Load,
    output logic             Commit_En,
    output logic             PC_Adv,
    output logic             Done,
    output logic             Timeout,
    output logic [CNT_W-1:0] Cycle_Count,
    output logic [CNT_W-1:0] Instr_Count
);

    localparam int unsigned WAIT_W   = 3;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT == 0) ? 0 : MEM_LAT - 1);
    localparam logic       WD_EN     = (MAX_CYCLES != 0);
    localparam logic [31:0] WD_LIMIT = 32'(MAX_CYCLES) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FETCH, S_EXEC, S_MEMWAIT, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ins_q, ins_d;
    logic               timeout_q, timeout_d;
    logic               commit_c, ir_load_c, run_c, wd_hit_c, cyc_inc_c, ins_inc_c;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            cyc_q     <= '0;
            ins_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cyc_d     = cyc_q;
        ins_d     = ins_q;
        timeout_d = timeout_q;
        commit_c  = 1'b0;
        ir_load_c = 1'b0;
        cyc_inc_c = 1'b0;
        ins_inc_c = 1'b0;
        run_c     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEMWAIT);
        wd_hit_c  = WD_EN && run_c && (32'(cyc_q) == WD_LIMIT);

        case (state_q)
            S_IDLE:  if (Start) state_d = S_INIT;
            S_INIT:  if (!Start) state_d = S_FETCH;
            S_FETCH: begin
                ir_load_c = 1'b1;
                cyc_inc_c = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                cyc_inc_c = 1'b1;
                if (Halt_Dec) begin
                    ins_inc_c = 1'b1;
                    state_d   = S_DONE;
                end else if (Load_Dec && (MEM_LAT != 0)) begin
                    wait_d  = WAIT_INIT;
                    state_d = S_MEMWAIT;
                end else begin
                    commit_c  = 1'b1;
                    ins_inc_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                cyc_inc_c = 1'b1;
                if (wait_q == '0) begin
                    commit_c  = 1'b1;
                    ins_inc_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_DONE:  if (Start) state_d = S_INIT;
            default: state_d = S_IDLE;
        endcase

        // Watchdog expiry swallows the cycle; an abort via Start overrides both it and a halt
        if (wd_hit_c) begin
            commit_c  = 1'b0;
            cyc_inc_c = 1'b0;
            ins_inc_c = 1'b0;
            timeout_d = 1'b1;
            state_d   = S_DONE;
        end
        if (run_c && Start) begin
            commit_c  = 1'b0;
            cyc_inc_c = 1'b0;
            ins_inc_c = 1'b0;
            state_d   = S_INIT;
        end

        if (cyc_inc_c && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);
        if (ins_inc_c && (ins_q != '1)) ins_d = ins_q + CNT_W'(1);

        // Counters and status are already clear in the first INIT cycle
        if (state_d == S_INIT) begin
            cyc_d     = '0;
            ins_d     = '0;
            timeout_d = 1'b0;
        end
    end

    assign PC_Rst      = (state_q == S_INIT);
    assign IR_Load     = ir_load_c;
    assign Commit_En   = commit_c;
    assign PC_Adv      = commit_c;
    assign Done        = (state_q == S_DONE);
    assign Timeout     = timeout_q;
    assign Cycle_Count = cyc_q;
    assign Instr_Count = ins_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: five parameterisations share stimulus, a scoreboard
// holds per-cycle expected outputs for whichever instance a step targets.
module tb_cpu_run_sequencer;

    localparam logic [5:0] E_IDLE = 6'b000000;
    localparam logic [5:0] E_INIT = 6'b100000;
    localparam logic [5:0] E_IR   = 6'b010000;
    localparam logic [5:0] E_CM   = 6'b001100;
    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_DONE = 6'b000010;
    localparam logic [5:0] E_TO   = 6'b000011;

    typedef struct {
        int         sel;
        logic [5:0] ctl;
        bit         cc;
        int         cyc;
        int         ins;
        string      tag;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n, Start, Halt_Dec, Load_Dec;
    logic [4:0] pr, ir, ce, pa, dn, to;
    logic [15:0] cy [4];
    logic [15:0] in_ [4];
    logic [2:0] cy_e, in_e;
    logic [5:0] ctl_v [5];
    logic [15:0] cyc_v [5];
    logic [15:0] ins_v [5];

    exp_t sb[$];
    int   sel;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    cpu_run_sequencer #(.MEM_LAT(1), .CNT_W(16), .MAX_CYCLES(0)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt_Dec(Halt_Dec), .Load_Dec(Load_Dec),
        .PC_Rst(pr[0]), .IR_Load(ir[0]), .Commit_En(ce[0]), .PC_Adv(pa[0]), .Done(dn[0]),
        .Timeout(to[0]), .Cycle_Count(cy[0]), .Instr_Count(in_[0]));
    cpu_run_sequencer #(.MEM_LAT(3), .CNT_W(16), .MAX_CYCLES(0)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt_Dec(Halt_Dec), .Load_Dec(Load_Dec),
        .PC_Rst(pr[1]), .IR_Load(ir[1]), .Commit_En(ce[1]), .PC_Adv(pa[1]), .Done(dn[1]),
        .Timeout(to[1]), .Cycle_Count(cy[1]), .Instr_Count(in_[1]));
    cpu_run_sequencer #(.MEM_LAT(0), .CNT_W(16), .MAX_CYCLES(0)) u_c (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt_Dec(Halt_Dec), .Load_Dec(Load_Dec),
        .PC_Rst(pr[2]), .IR_Load(ir[2]), .Commit_En(ce[2]), .PC_Adv(pa[2]), .Done(dn[2]),
        .Timeout(to[2]), .Cycle_Count(cy[2]), .Instr_Count(in_[2]));
    cpu_run_sequencer #(.MEM_LAT(1), .CNT_W(16), .MAX_CYCLES(7)) u_d (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt_Dec(Halt_Dec), .Load_Dec(Load_Dec),
        .PC_Rst(pr[3]), .IR_Load(ir[3]), .Commit_En(ce[3]), .PC_Adv(pa[3]), .Done(dn[3]),
        .Timeout(to[3]), .Cycle_Count(cy[3]), .Instr_Count(in_[3]));
    cpu_run_sequencer #(.MEM_LAT(1), .CNT_W(3), .MAX_CYCLES(0)) u_e (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt_Dec(Halt_Dec), .Load_Dec(Load_Dec),
        .PC_Rst(pr[4]), .IR_Load(ir[4]), .Commit_En(ce[4]), .PC_Adv(pa[4]), .Done(dn[4]),
        .Timeout(to[4]), .Cycle_Count(cy_e), .Instr_Count(in_e));

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            ctl_v[i] = {pr[i], ir[i], ce[i], pa[i], dn[i], to[i]};
            cyc_v[i] = (i < 4) ? cy[i] : 16'(cy_e);
            ins_v[i] = (i < 4) ? in_[i] : 16'(in_e);
        end
    end

    // Scoreboard drain: one expected entry per checked cycle, compared mid-cycle
    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            assert (ctl_v[e.sel] === e.ctl) else begin
                errors++;
                $error("FAIL %s ctl{pcrst,irld,commit,pcadv,done,tmo} observed=%b expected=%b",
                       e.tag, ctl_v[e.sel], e.ctl);
            end
            if (e.cc) begin
                checks++;
                assert ({cyc_v[e.sel], ins_v[e.sel]} === {16'(e.cyc), 16'(e.ins)}) else begin
                    errors++;
                    $error("FAIL %s counters observed cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                           e.tag, cyc_v[e.sel], ins_v[e.sel], e.cyc, e.ins);
                end
            end
        end
    end

    task automatic step(input logic st, input logic h, input logic l, input bit chk,
                        input logic [5:0] ctl, input bit cc, input int cyc, input int ins,
                        input string tag);
        exp_t e;
        Start    = st;
        Halt_Dec = h;
        Load_Dec = l;
        if (chk) begin
            e.sel = sel; e.ctl = ctl; e.cc = cc; e.cyc = cyc; e.ins = ins; e.tag = tag;
            sb.push_back(e);
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        sel = 0; Reset_n = 1'b0; Start = 1'b0; Halt_Dec = 1'b0; Load_Dec = 1'b0;
        @(posedge Clk);
        #1;
        step(0, 0, 0, 1, E_IDLE, 1, 0, 0, "reset_idle");
        Reset_n = 1'b1;

        // Start held 3 cycles, 4 plain instructions then halt (MEM_LAT=1)
        step(1, 0, 0, 1, E_IDLE, 0, 0, 0, "idle_start");
        step(1, 0, 0, 1, E_INIT, 1, 0, 0, "init1");
        step(1, 0, 0, 1, E_INIT, 0, 0, 0, "init2");
        step(0, 0, 0, 1, E_INIT, 0, 0, 0, "init3");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, E_IR, (i < 2), 2 * i, i, "fetch");
            step(0, (i == 4), 0, 1, (i == 4) ? E_NONE : E_CM, 0, 0, 0, "exec");
        end
        step(0, 0, 0, 1, E_DONE, 1, 10, 5, "halt_done");
        step(0, 0, 0, 1, E_DONE, 1, 10, 5, "done_hold");

        // Load with MEM_LAT=3
        sel = 1;
        step(1, 0, 0, 1, E_DONE, 0, 0, 0, "done_start");
        step(0, 0, 0, 1, E_INIT, 1, 0, 0, "done_drop");
        step(0, 0, 0, 1, E_IR,   1, 0, 0, "ld3_fetch");
        step(0, 0, 1, 1, E_NONE, 0, 0, 0, "ld3_exec");
        step(0, 0, 0, 1, E_NONE, 0, 0, 0, "ld3_wait_a");
        step(0, 0, 0, 1, E_NONE, 0, 0, 0, "ld3_wait_b");
        step(0, 0, 0, 1, E_CM,   0, 0, 0, "ld3_commit");
        step(0, 0, 0, 1, E_IR,   1, 5, 1, "ld3_next");
        step(0, 1, 0, 1, E_NONE, 0, 0, 0, "ld3_halt");
        step(0, 0, 0, 1, E_DONE, 1, 7, 2, "ld3_done");

        // Load with MEM_LAT=0 commits in EXEC
        sel = 2;
        step(1, 0, 0, 0, E_NONE, 0, 0, 0, "restart");
        step(0, 0, 0, 1, E_INIT, 1, 0, 0, "ld0_init");
        step(0, 0, 0, 1, E_IR,   0, 0, 0, "ld0_fetch");
        step(0, 0, 1, 1, E_CM,   0, 0, 0, "ld0_commit");
        step(0, 0, 0, 1, E_IR,   1, 2, 1, "ld0_next");
        step(0, 1, 0, 1, E_NONE, 0, 0, 0, "ld0_halt");
        step(0, 0, 0, 1, E_DONE, 1, 4, 2, "ld0_done");

        // Watchdog at 7 run cycles, with a halt decoded in the expiring cycle
        sel = 3;
        step(1, 0, 0, 0, E_NONE, 0, 0, 0, "restart");
        step(0, 0, 0, 1, E_INIT, 1, 0, 0, "wd_init");
        step(0, 0, 0, 1, E_IR,   0, 0, 0, "wd_c1");
        step(0, 0, 1, 1, E_NONE, 0, 0, 0, "wd_c2");
        step(0, 0, 0, 1, E_CM,   0, 0, 0, "wd_c3");
        step(0, 0, 0, 1, E_IR,   0, 0, 0, "wd_c4");
        step(0, 0, 0, 1, E_CM,   0, 0, 0, "wd_c5");
        step(0, 0, 0, 1, E_IR,   1, 5, 2, "wd_c6");
        step(0, 1, 0, 1, E_NONE, 1, 6, 2, "wd_c7_halt");
        step(0, 0, 0, 1, E_TO,   1, 6, 2, "wd_timeout");
        step(0, 0, 0, 1, E_TO,   1, 6, 2, "wd_hold");

        // Abort via Start in the final MEMWAIT cycle, then reset during EXEC
        sel = 1;
        step(1, 0, 0, 0, E_NONE, 0, 0, 0, "restart");
        step(0, 0, 0, 1, E_INIT, 1, 0, 0, "ab_init");
        step(0, 0, 0, 1, E_IR,   0, 0, 0, "ab_fetch");
        step(0, 0, 1, 1, E_NONE, 0, 0, 0, "ab_exec");
        step(0, 0, 0, 1, E_NONE, 0, 0, 0, "ab_wait_a");
        step(0, 0, 0, 1, E_NONE, 0, 0, 0, "ab_wait_b");
        step(1, 0, 0, 1, E_NONE, 1, 4, 0, "ab_no_commit");
        step(0, 0, 0, 1, E_INIT, 1, 0, 0, "ab_to_init");
        sel = 0;
        step(0, 0, 0, 1, E_IR,   0, 0, 0, "rst_fetch");
        Reset_n = 1'b0;
        step(0, 0, 0, 0, E_NONE, 0, 0, 0, "rst_exec");
        Reset_n = 1'b1;
        step(0, 0, 0, 1, E_IDLE, 1, 0, 0, "rst_idle");

        // Counter saturation with CNT_W=3 over a 12-instruction program
        sel = 4;
        step(1, 0, 0, 1, E_IDLE, 1, 0, 0, "sat_idle");
        step(0, 0, 0, 1, E_INIT, 1, 0, 0, "sat_init");
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, E_IR, (i == 4), 7, 4, "sat_fetch");
            step(0, (i == 11), 0, 1, (i == 11) ? E_NONE : E_CM, 0, 0, 0, "sat_exec");
        end
        step(0, 0, 0, 1, E_DONE, 1, 7, 7, "sat_done");

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clk);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
